// File: rtl/store_buffer_pkg.sv
// Shared types for the store buffer: size encodings, pointer/index widths and the entry record.
package store_buffer_pkg;

    localparam int unsigned SB_PTR_W = 4;
    localparam int unsigned SB_IDX_W = 3;

    typedef enum logic [1:0] {
        SizeByte = 2'b00,
        SizeHalf = 2'b01,
        SizeWord = 2'b10
    } sb_size_e;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  size;
        logic        filled;
    } sb_entry_t;

endpackage

// File: rtl/sb_fwd_match.sv
// Load-forwarding search: youngest filled, allocated entry whose word address matches the load.
module sb_fwd_match
    import store_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  sb_entry_t           entries [DEPTH],
    input  logic [SB_PTR_W-1:0] read_point,
    input  logic [SB_PTR_W-1:0] write_point,
    input  logic [31:0]         ld_addr,
    output logic                hit,
    output logic [31:0]         data,
    output logic                conflict
);

    logic [SB_PTR_W-1:0] occupancy;
    logic                found;
    logic [31:0]         sel_data;
    logic [1:0]          sel_size;
    logic [SB_IDX_W-1:0] idx;
    logic [DEPTH-1:0]    unused_low_bits;

    assign occupancy = write_point - read_point;

    // Walk from oldest to youngest so the last match seen is the youngest.
    always_comb begin
        found    = 1'b0;
        sel_data = '0;
        sel_size = '0;
        idx      = '0;
        for (int age = 0; age < int'(DEPTH); age++) begin
            idx = read_point[SB_IDX_W-1:0] + SB_IDX_W'(age);
            if ((SB_PTR_W'(age) < occupancy) && entries[idx].filled &&
                (entries[idx].addr[31:2] == ld_addr[31:2])) begin
                found    = 1'b1;
                sel_data = entries[idx].data;
                sel_size = entries[idx].size;
            end
        end
    end

    assign hit      = found && (sel_size == SizeWord);
    assign conflict = found && (sel_size != SizeWord);
    assign data     = hit ? sel_data : '0;

    for (genvar i = 0; i < int'(DEPTH); i++) begin : g_unused
        assign unused_low_bits[i] = ^entries[i].addr[1:0];
    end

endmodule

// File: rtl/store_buffer.sv
// Store buffer: holds dispatched stores until retired, then drains them one per cycle to the
// data cache. Load forwarding is built only when SB_LD_FWD_EN is defined.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [SB_PTR_W-1:0] sb_write_point,
    input  logic                agu_wr_en,
    input  logic [SB_IDX_W-1:0] agu_wr_idx,
    input  logic [31:0]         agu_addr,
    input  logic [31:0]         agu_data,
    input  logic [1:0]          agu_size,
    input  logic                commit_1,
    input  logic                commit_2,
    input  logic                flush,
    output logic                dc_req,
    output logic [31:0]         dc_addr,
    output logic [31:0]         dc_wdata,
    output logic [1:0]          dc_size,
    input  logic                dc_ack,
    output logic [SB_PTR_W-1:0] sb_read_point,
    output logic [SB_PTR_W-1:0] sb_commit_point,
    input  logic [31:0]         ld_addr,
    output logic                ld_hit,
    output logic [31:0]         ld_data,
    output logic                ld_conflict,
    output logic                sb_empty
);

    typedef enum logic {StIdle, StReq} state_e;
    typedef logic [SB_PTR_W-1:0] ptr_t;
    typedef logic [SB_IDX_W-1:0] idx_t;

    // Distance of an entry index from the head, modulo the buffer depth.
    function automatic ptr_t age_of(input idx_t idx, input ptr_t base);
        idx_t diff;
        diff = idx - base[SB_IDX_W-1:0];
        return {1'b0, diff};
    endfunction

    state_e      state_q, state_d;
    ptr_t        read_q, read_d, commit_q, commit_d;
    sb_entry_t   entries_q [DEPTH];
    sb_entry_t   entries_d [DEPTH];
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
    logic [1:0]  size_q, size_d;

    ptr_t occupancy, commit_room, commit_inc;
    idx_t head_idx, next_idx;

    assign occupancy   = sb_write_point - read_q;
    assign commit_room = sb_write_point - commit_q;
    assign commit_inc  = ptr_t'(commit_1) + ptr_t'(commit_2);
    assign commit_d    = commit_q + ((commit_inc > commit_room) ? commit_room : commit_inc);
    assign head_idx    = read_q[SB_IDX_W-1:0];
    assign next_idx    = head_idx + idx_t'(1);

    always_comb begin
        entries_d = entries_q;
        read_d    = read_q;
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        size_d    = size_q;

        if (agu_wr_en && (age_of(agu_wr_idx, read_q) < occupancy)) begin
            entries_d[agu_wr_idx] = '{addr: agu_addr, data: agu_data, size: agu_size,
                                      filled: 1'b1};
        end

        // Flush sees this cycle's commits first, so only still-speculative entries are dropped.
        if (flush) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (age_of(idx_t'(i), read_q) >= (commit_d - read_q)) begin
                    entries_d[idx_t'(i)].filled = 1'b0;
                end
            end
        end

        unique case (state_q)
            StIdle: begin
                if ((commit_q != read_q) && entries_q[head_idx].filled) begin
                    state_d = StReq;
                    addr_d  = entries_q[head_idx].addr;
                    wdata_d = entries_q[head_idx].data;
                    size_d  = entries_q[head_idx].size;
                end
            end
            StReq: begin
                if (dc_ack) begin
                    read_d                     = read_q + ptr_t'(1);
                    entries_d[head_idx].filled = 1'b0;
                    if ((read_d != commit_q) && entries_q[next_idx].filled) begin
                        addr_d  = entries_q[next_idx].addr;
                        wdata_d = entries_q[next_idx].data;
                        size_d  = entries_q[next_idx].size;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            read_q   <= '0;
            commit_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            size_q   <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                entries_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            read_q    <= read_d;
            commit_q  <= commit_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            size_q    <= size_d;
            entries_q <= entries_d;
        end
    end

    assign dc_req          = (state_q == StReq);
    assign dc_addr         = addr_q;
    assign dc_wdata        = wdata_q;
    assign dc_size         = size_q;
    assign sb_read_point   = read_q;
    assign sb_commit_point = commit_q;
    assign sb_empty        = (read_q == sb_write_point);

`ifdef SB_LD_FWD_EN
    sb_fwd_match #(
        .DEPTH(DEPTH)
    ) u_fwd_match (
        .entries    (entries_q),
        .read_point (read_q),
        .write_point(sb_write_point),
        .ld_addr    (ld_addr),
        .hit        (ld_hit),
        .data       (ld_data),
        .conflict   (ld_conflict)
    );
`else
    logic unused_ld_addr;
    assign unused_ld_addr = ^ld_addr;
    assign ld_hit         = 1'b0;
    assign ld_data        = '0;
    assign ld_conflict    = 1'b0;
`endif

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of entries (power of two); pointers are log2(DEPTH)+1 bits, the MSB being the wrap bit.
REQ-002 SHALL have ports: clk  in  1  clock, rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 sb_write_point  in  4  dispatch allocation pointer; entries in [sb_read_point, sb_write_point) are allocated.
REQ-005 agu_wr_en  in  1  AGU result write; agu_wr_idx  in  3  entry index; agu_addr  in  32; agu_data  in  32; agu_size  in  2 (00 byte, 01 half, 10 word).
REQ-006 commit_1, commit_2  in  1 each  ROB retires 1st/2nd oldest store this cycle; commit_2 without commit_1 is illegal.
REQ-007 flush  in  1  pipeline flush.
REQ-008 dc_req  out  1; dc_addr  out  32; dc_wdata  out  32; dc_size  out  2; dc_ack  in  1  data-cache write handshake.
REQ-009 sb_read_point  out  4  oldest undrained entry; sb_commit_point  out  4  first uncommitted entry.
REQ-010 ld_addr  in  32; ld_hit  out  1; ld_data  out  32; ld_conflict  out  1  load forwarding (see Configuration).
REQ-011 sb_empty  out  1  high when sb_read_point == sb_write_point.

Function
REQ-012 Occupancy SHALL be sb_write_point - sb_read_point (4-bit modular); full = (sb_write_point ^ sb_read_point) == 4'b1000.
REQ-013 On agu_wr_en, the entry agu_wr_idx SHALL capture addr/data/size and set its filled bit at the next edge; writes to unallocated entries are ignored.
REQ-014 commit_1/commit_2 SHALL advance sb_commit_point by 1/2 at the next edge, saturating at sb_write_point.
REQ-015 Drain FSM states: IDLE, REQ.
REQ-016 IDLE->REQ when the head entry (sb_read_point) is committed and filled; dc_req is registered, asserted the cycle after the condition holds.
REQ-017 In REQ: dc_req=1; dc_addr/dc_wdata/dc_size SHALL be held stable until dc_ack.
REQ-018 REQ on dc_ack: sb_read_point+1 and the head filled bit cleared at the same edge; next state REQ if the new head is committed+filled, else IDLE (back-to-back drain, 1 store/cycle).
REQ-019 Pointers SHALL wrap modulo 16 with wrap-bit toggle at index DEPTH-1 -> 0.
REQ-020 flush SHALL clear filled bits of all uncommitted entries; committed entries keep draining; sb_commit_point unchanged; dispatch restores its write pointer from sb_commit_point.
REQ-021 flush + commit in the same cycle: commit applied first, then flush discards only entries still uncommitted.
REQ-022 dc_ack while in IDLE SHALL be ignored.

Reset
REQ-023 On reset low: pointers 0, all filled bits 0, FSM IDLE, dc_req 0, dc_addr/dc_wdata 0, dc_size 0, ld_hit 0, ld_conflict 0, sb_empty 1; a reset mid-transaction drops dc_req immediately.

Configuration
REQ-024 Macro SB_LD_FWD_EN: defined -> ld_hit=1 and ld_data = data of the youngest filled allocated entry with addr[31:2]==ld_addr[31:2] and size word; ld_conflict=1 if the youngest match has size not word; combinational. Undefined -> ld_hit=0, ld_conflict=0, ld_data=0, ports retained.

Structure
REQ-025 Shared package SHALL hold the size encodings, SB_PTR_W=4, SB_IDX_W=3, and the entry struct {addr, data, size, filled}.
REQ-026 Forwarding search SHALL be a sub-module sb_fwd_match (priority match from head-relative age), instantiated only under SB_LD_FWD_EN.

Verification
REQ-027 Alloc 1 (write_point 0->1), AGU idx0 addr 0x100 data 0xDEADBEEF size 10, commit_1 -> dc_req next cycle with 0x100/0xDEADBEEF; dc_ack -> sb_read_point=1, sb_empty=1.
REQ-028 8 allocated, filled and committed, dc_ack held high -> 8 consecutive drains, sb_read_point 0->8 (wrap bit set).
REQ-029 4 allocated, 2 committed, flush -> exactly 2 drains; entries 2,3 never requested; sb_commit_point=2.
REQ-030 dc_ack low for 5 cycles in REQ -> dc_req/dc_addr/dc_wdata stable throughout.
REQ-031 Reset asserted during REQ -> dc_req 0 asynchronously, pointers 0.
REQ-032 SB_LD_FWD_EN: entries addr 0x200 data 1 (older) and 0x200 data 2 (younger), ld_addr 0x200 -> ld_hit=1, ld_data=2; younger entry byte-sized -> ld_conflict=1.
